// File: rtl/nes_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : nes_clock_enable_gen
// Purpose  : Multi-channel clock-enable generator for a single-clock NES core.
//            Waits for the PLL lock to stay high for LOCK_CYCLES consecutive
//            cycles and then emits phase-aligned one-cycle enable strobes
//            from integer dividers (PPU /4, CPU /12 by default). Any loss of
//            lock drops back to lock qualification and restarts all channels
//            in phase.
// Optional : define CLKGEN_FRAC_CH_EN to add a fractional-rate strobe driven
//            by an ACC_W-bit phase accumulator (e.g. an audio sample tick).
// Ports    : refclk     - master clock (PLL outclk_0)
//            rst        - asynchronous active-high reset
//            pll_locked - PLL lock flag, synchronous to refclk
//            halt       - freezes all dividers while high (RUN only)
//            ready      - high while the generator is running
//            ce         - per-channel one-cycle enable strobes
//            ce_frac    - fractional-rate strobe (CLKGEN_FRAC_CH_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module nes_clock_enable_gen #(
  parameter int                       NUM_CH      = 2,
  parameter int                       DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]  DIVISORS    = 16'h0C04,
  parameter int                       LOCK_CYCLES = 16
`ifdef CLKGEN_FRAC_CH_EN
  ,
  parameter int                       ACC_W       = 24,
  parameter int                       FRAC_INC    = 34449
`endif
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              halt,
  output logic              ready,
  output logic [NUM_CH-1:0] ce
`ifdef CLKGEN_FRAC_CH_EN
  ,
  output logic              ce_frac
`endif
);

  // Stable counter only has to reach LOCK_CYCLES before leaving STABLE.
  localparam int               STB_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [STB_W-1:0] LOCK_TGT = STB_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [STB_W-1:0]   stb_q, stb_d;
  logic               ready_q, ready_d;
  logic [NUM_CH-1:0]  ce_q, ce_d;
  logic [DIV_W-1:0]   cnt_q [NUM_CH];
  logic [DIV_W-1:0]   cnt_d [NUM_CH];
  logic [DIV_W-1:0]   div   [NUM_CH];

  // run_active: this edge is a counting cycle (running, locked, not halted).
  // run_exit  : lock lost while running; everything restarts from zero.
  logic               run_active;
  logic               run_exit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_div
    assign div[i] = DIVISORS[i*DIV_W +: DIV_W];
  end

  // --------------------------------------------------------------------------
  // Lock qualification state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    ready_d    = 1'b0;
    run_active = 1'b0;
    run_exit   = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (pll_locked) begin
          // This sample is the first locked cycle of the streak.
          stb_d   = STB_W'(1);
          state_d = (LOCK_TGT == STB_W'(1)) ? ST_RUN : ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!pll_locked) begin
          stb_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          stb_d = stb_q + STB_W'(1);
          if (stb_q + STB_W'(1) == LOCK_TGT) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!pll_locked) begin
          // Lock loss wins over halt and over any wrap on this edge.
          stb_d    = '0;
          state_d  = ST_WAIT_LOCK;
          run_exit = 1'b1;
        end else begin
          ready_d    = 1'b1;
          run_active = !halt;
        end
      end
      default: begin
        stb_d   = '0;
        state_d = ST_WAIT_LOCK;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Integer divider channels: all counters start at zero on entry to RUN, so
  // channels whose divisors share factors stay phase-aligned.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    ce_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (run_exit) begin
        cnt_d[i] = '0;
      end else if (run_active && (div[i] != '0)) begin
        // Divisor 1 wraps every cycle; divisor 0 never counts.
        if (cnt_q[i] == div[i] - DIV_W'(1)) begin
          cnt_d[i] = '0;
          ce_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT_LOCK;
      stb_q   <= '0;
      ready_q <= 1'b0;
      ce_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      ready_q <= ready_d;
      ce_q    <= ce_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ready = ready_q;
  assign ce    = ce_q;

`ifdef CLKGEN_FRAC_CH_EN
  // --------------------------------------------------------------------------
  // Fractional channel: carry out of the phase accumulator is the strobe.
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_frac_q, ce_frac_d;

  always_comb begin
    acc_d     = acc_q;
    ce_frac_d = 1'b0;
    if (run_exit) begin
      acc_d = '0;
    end else if (run_active) begin
      {ce_frac_d, acc_d} = {1'b0, acc_q} + (ACC_W+1)'(FRAC_INC);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      ce_frac_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ce_frac_q <= ce_frac_d;
    end
  end

  assign ce_frac = ce_frac_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nes_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_clock_enable_gen
// Purpose  : Self-checking bench for nes_clock_enable_gen. Two instances share
//            the stimulus: A uses the default divisors (4, 12) and lock time
//            16; B uses divisors (1, 0) and lock time 4. A per-cycle model
//            derives outputs from the lock streak length and the number of
//            active cycles since RUN began.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_clock_enable_gen;

  localparam int LOCK_A = 16;
  localparam int LOCK_B = 4;
`ifdef CLKGEN_FRAC_CH_EN
  localparam int ACC_W  = 8;
  localparam int INC_A  = 64;
  localparam int INC_B  = 96;
`endif

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       halt = 1'b0;
  logic       ready_a, ready_b;
  logic [1:0] ce_a, ce_b;
`ifdef CLKGEN_FRAC_CH_EN
  logic       frac_a, frac_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 refclk = ~refclk;

  nes_clock_enable_gen dut_a (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .halt       (halt),
    .ready      (ready_a),
    .ce         (ce_a)
`ifdef CLKGEN_FRAC_CH_EN
    ,
    .ce_frac    (frac_a)
`endif
  );

  nes_clock_enable_gen #(
    .NUM_CH      (2),
    .DIV_W       (8),
    .DIVISORS    (16'h0001),
    .LOCK_CYCLES (LOCK_B)
`ifdef CLKGEN_FRAC_CH_EN
    ,
    .ACC_W       (ACC_W),
    .FRAC_INC    (INC_B)
`endif
  ) dut_b (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .halt       (halt),
    .ready      (ready_b),
    .ce         (ce_b)
`ifdef CLKGEN_FRAC_CH_EN
    ,
    .ce_frac    (frac_b)
`endif
  );

`ifdef CLKGEN_FRAC_CH_EN
  defparam dut_a.ACC_W    = ACC_W;
  defparam dut_a.FRAC_INC = INC_A;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model. streak = consecutive locked samples since reset or the
  // last unlocked sample; running once streak exceeds the lock time. nact =
  // active cycles since RUN began; channel D pulses when nact is a multiple
  // of D.
  // --------------------------------------------------------------------------
  int         streak = 0;
  int         nact_a = 0, nact_b = 0;
  logic       exp_ready_a, exp_ready_b;
  logic [1:0] exp_ce_a, exp_ce_b;
`ifdef CLKGEN_FRAC_CH_EN
  logic       exp_frac_a, exp_frac_b;

  function automatic logic frac_pulse(input int n, input int inc);
    longint hi, lo;
    hi = (longint'(n) * inc) >> ACC_W;
    lo = (longint'(n - 1) * inc) >> ACC_W;
    return hi != lo;
  endfunction
`endif

  task automatic model_inst(input int lock, input int d0, input int d1,
                            inout int nact, output logic rdy, output logic [1:0] cev);
    rdy = (streak >= lock + 1);
    cev = 2'b00;
    if (!rdy) begin
      nact = 0;
    end else if (!halt) begin
      nact++;
      cev[0] = (d0 != 0) && (nact % d0 == 0);
      cev[1] = (d1 != 0) && (nact % d1 == 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge refclk);
      if (rst) begin
        streak = 0;
        nact_a = 0;
        nact_b = 0;
      end else begin
        streak = pll_locked ? streak + 1 : 0;
      end
      model_inst(LOCK_A, 4, 12, nact_a, exp_ready_a, exp_ce_a);
      model_inst(LOCK_B, 1, 0, nact_b, exp_ready_b, exp_ce_b);
`ifdef CLKGEN_FRAC_CH_EN
      exp_frac_a = exp_ready_a && !halt && frac_pulse(nact_a, INC_A);
      exp_frac_b = exp_ready_b && !halt && frac_pulse(nact_b, INC_B);
`endif
      @(negedge refclk);
      if (rst) begin
        exp_ready_a = 1'b0;
        exp_ready_b = 1'b0;
        exp_ce_a    = 2'b00;
        exp_ce_b    = 2'b00;
`ifdef CLKGEN_FRAC_CH_EN
        exp_frac_a  = 1'b0;
        exp_frac_b  = 1'b0;
`endif
      end
      chk("model_ready_a", ready_a, exp_ready_a);
      chk("model_ce_a", ce_a, exp_ce_a);
      chk("model_ready_b", ready_b, exp_ready_b);
      chk("model_ce_b", ce_b, exp_ce_b);
`ifdef CLKGEN_FRAC_CH_EN
      chk("model_frac_a", frac_a, exp_frac_a);
      chk("model_frac_b", frac_b, exp_frac_b);
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Returns the edge index (1-based) at which ready_a first reads high.
  task automatic wait_ready(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready_a) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k, act, c0, c1, b0, b1, first0, first1, misal, hs, rlo;
`ifdef CLKGEN_FRAC_CH_EN
    int fa;
`endif
    rst = 1'b1;
    pll_locked = 1'b0;
    halt = 1'b0;
    tick(); tick(); tick();
    chk("rst_ready_a", ready_a, 0);
    chk("rst_ce_a", ce_a, 0);
    chk("rst_ready_b", ready_b, 0);
    rst = 1'b0;
    tick();

    // Lock qualification
    pll_locked = 1'b1;
    wait_ready(k);
    chk("lock_latency", k, 17);

    // 48 active cycles with default divisors; the ready edge is active 1
    act = 1;
    c0 = ce_a[0]; c1 = ce_a[1]; b0 = ce_b[0]; b1 = ce_b[1];
    first0 = ce_a[0] ? 1 : 0;
    misal = 0;
`ifdef CLKGEN_FRAC_CH_EN
    fa = frac_a;
`endif
    while (act < 48) begin
      tick();
      act++;
      c0 += ce_a[0]; c1 += ce_a[1]; b0 += ce_b[0]; b1 += ce_b[1];
      if (ce_a[0] && first0 == 0) first0 = act;
      if (ce_a[1] && !ce_a[0]) misal++;
`ifdef CLKGEN_FRAC_CH_EN
      fa += frac_a;
`endif
    end
    chk("ce0_count_48", c0, 12);
    chk("ce1_count_48", c1, 4);
    chk("ce0_first", first0, 4);
    chk("ce1_align", misal, 0);
    chk("b_ce0_every_cycle", b0, 48);
    chk("b_ce1_never", b1, 0);
`ifdef CLKGEN_FRAC_CH_EN
    chk("frac_count_48", fa, 12);
`endif

    // Halt for 5 cycles starting at active cycle 6
    repeat (5) tick();
    halt = 1'b1;
    hs = 0;
    rlo = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      hs += ce_a[0] + ce_a[1] + ce_b[0];
      if (!ready_a) rlo++;
    end
    chk("halt_strobes", hs, 0);
    chk("halt_ready_kept", rlo, 0);
    halt = 1'b0;
    first0 = 0;
    first1 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ce_a[0] && first0 == 0) first0 = i;
      if (ce_a[1]) begin
        first1 = i;
        break;
      end
    end
    chk("halt_resume_ce0", first0, 3);
    chk("halt_resume_ce1", first1, 7);
    chk("halt_resume_align", ce_a, 2'b11);

    // Lock loss exactly when ce[1] would fire (active 24 of this phase)
    repeat (11) tick();
    pll_locked = 1'b0;
    tick();
    chk("loss_ce_suppressed", ce_a, 0);
    chk("loss_ready_low", ready_a, 0);
    pll_locked = 1'b1;
    wait_ready(k);
    chk("relock_latency", k, 17);
    first0 = ce_a[0] ? 1 : 0;
    first1 = 0;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (ce_a[0] && first0 == 0) first0 = i;
      if (ce_a[1]) begin
        first1 = i;
        break;
      end
    end
    chk("relock_first_ce0", first0, 4);
    chk("relock_first_ce1", first1, 12);

    // One-cycle lock glitch at locked cycle 10 restarts qualification
    pll_locked = 1'b0;
    tick(); tick();
    pll_locked = 1'b1;
    repeat (9) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_ready(k);
    chk("glitch_relock_latency", k, 17);

    // Randomized lock drops and halts, checked by the model every cycle
    for (int i = 0; i < 2500; i++) begin
      pll_locked = ($urandom_range(0, 63) != 0);
      halt       = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Asynchronous reset in the middle of RUN
    pll_locked = 1'b1;
    halt = 1'b0;
    repeat (30) tick();
    chk("pre_rst_ready_a", ready_a, 1);
    chk("pre_rst_ce_b", ce_b, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready_a", ready_a, 0);
    chk("async_rst_ce_a", ce_a, 0);
    chk("async_rst_ready_b", ready_b, 0);
    chk("async_rst_ce_b", ce_b, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
